// File: rtl/spi_debug_master.sv
// SPI mode-3 initiator that reads one 16-bit word from the CPU debug slave.
// Each frame is 18 sclk periods: a 2-bit address goes out MSB first, then
// 16 data bits come back MSB first. CLK_DIV is the sclk half-period in
// clk_i cycles and must lie in 2..255 (the half-period counter is 8 bits).
module spi_debug_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        start_i,
    input  logic [1:0]  addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] data_o,
    output logic        sclk_o,
    output logic        csb_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned EDGE_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 2;

    localparam logic [CNT_W-1:0]  CNT_RELOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] FIRST_DATA  = EDGE_W'(3);
    localparam logic [EDGE_W-1:0] LAST_PERIOD = EDGE_W'(18);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [EDGE_W-1:0]   edge_q,   edge_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   shift_q,  shift_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic                sclk_q,   sclk_d;
    logic                csb_q,    csb_d;
    logic                mosi_q,   mosi_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            sclk_q  <= 1'b1;
            csb_q   <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            sclk_q  <= sclk_d;
            csb_q   <= csb_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        data_d  = data_q;
        sclk_d  = sclk_q;
        csb_d   = csb_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = CNT_RELOAD;
                if (start_i) begin
                    state_d = SETUP;
                    addr_d  = addr_i;
                    edge_d  = '0;
                    csb_d   = 1'b0;
                    sclk_d  = 1'b1;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = CNT_RELOAD;
                    sclk_d  = 1'b0;
                    mosi_d  = addr_q[1];
                    edge_d  = EDGE_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // Last low cycle raises sclk and samples miso; the slave has
            // held it stable since the preceding falling edge.
            LOW: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = CNT_RELOAD;
                    sclk_d  = 1'b1;
                    if (edge_q >= FIRST_DATA) begin
                        shift_d = {shift_q[DATA_W-2:0], miso_i};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // mosi only moves together with a falling sclk.
            HIGH: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (edge_q == LAST_PERIOD) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        state_d = LOW;
                        sclk_d  = 1'b0;
                        edge_d  = edge_q + EDGE_W'(1);
                        mosi_d  = (edge_q == EDGE_W'(1)) ? addr_q[0] : 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CNT_RELOAD;
                    csb_d   = 1'b1;
                    done_d  = 1'b1;
                    data_d  = shift_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // A start pending at the end of the gap chains the next frame
            // directly, so held start gives exactly CLK_DIV cycles of csb high.
            GAP: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_RELOAD;
                    if (start_i) begin
                        state_d = SETUP;
                        addr_d  = addr_i;
                        edge_d  = '0;
                        csb_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign data_o = data_q;
    assign sclk_o = sclk_q;
    assign csb_o  = csb_q;
    assign mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_debug_master.sv
// Directed bench for spi_debug_master with a behavioural mode-3 debug slave.
// Instance 0 uses CLK_DIV=4, instance 1 uses CLK_DIV=2.
module tb_spi_debug_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start4, start2;
    logic [1:0]  addr4, addr2;
    logic        busy4, done4, sclk4, csb4, mosi4, miso4;
    logic        busy2, done2, sclk2, csb2, mosi2, miso2;
    logic [15:0] data4, data2;

    int tests_run    = 0;
    int tests_failed = 0;

    // Slave register file per instance: 0 regD, 1 regA, 2 pc, 3 state
    logic [15:0] sregs [2][4];
    int          scnt [2];
    logic [1:0]  saddr [2];
    logic        prev_sclk [2];
    int          run_len [2];
    int          fall_cnt [2];
    int          phase_err [2];
    logic        mosi_log [2][19];

    always #5 clk = ~clk;

    spi_debug_master #(.CLK_DIV(4)) dut4 (
        .clk_i(clk), .reset(reset), .start_i(start4), .addr_i(addr4),
        .busy_o(busy4), .done_o(done4), .data_o(data4),
        .sclk_o(sclk4), .csb_o(csb4), .mosi_o(mosi4), .miso_i(miso4)
    );

    spi_debug_master #(.CLK_DIV(2)) dut2 (
        .clk_i(clk), .reset(reset), .start_i(start2), .addr_i(addr2),
        .busy_o(busy2), .done_o(done2), .data_o(data2),
        .sclk_o(sclk2), .csb_o(csb2), .mosi_o(mosi2), .miso_i(miso2)
    );

    function automatic logic f_sclk(input int g);
        return (g == 0) ? sclk4 : sclk2;
    endfunction

    function automatic logic f_csb(input int g);
        return (g == 0) ? csb4 : csb2;
    endfunction

    function automatic logic f_mosi(input int g);
        return (g == 0) ? mosi4 : mosi2;
    endfunction

    function automatic logic f_bit(input int g, input int p);
        logic [15:0] w;
        w = sregs[g][saddr[g]];
        return w[4'(18 - p)];
    endfunction

    // Slave model plus sclk phase-length and edge monitors.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                scnt[g]      <= 0;
                prev_sclk[g] <= 1'b1;
                run_len[g]   <= 1;
                if (g == 0) miso4 <= 1'b0; else miso2 <= 1'b0;
            end else begin
                if (f_sclk(g) == prev_sclk[g]) begin
                    run_len[g] <= run_len[g] + 1;
                end else begin
                    run_len[g] <= 1;
                    if (!f_csb(g)) begin
                        if (!f_sclk(g)) begin
                            fall_cnt[g] <= fall_cnt[g] + 1;
                            if (scnt[g] != 0 && run_len[g] != ((g == 0) ? 4 : 2))
                                phase_err[g] <= phase_err[g] + 1;
                            if (scnt[g] + 1 >= 3) begin
                                if (g == 0) miso4 <= f_bit(g, scnt[g] + 1);
                                else        miso2 <= f_bit(g, scnt[g] + 1);
                            end
                        end else begin
                            if (run_len[g] != ((g == 0) ? 4 : 2))
                                phase_err[g] <= phase_err[g] + 1;
                            mosi_log[g][scnt[g] + 1] <= f_mosi(g);
                            if (scnt[g] == 0) saddr[g][1] <= f_mosi(g);
                            if (scnt[g] == 1) saddr[g][0] <= f_mosi(g);
                            scnt[g] <= (scnt[g] == 17) ? 0 : scnt[g] + 1;
                        end
                    end
                end
                prev_sclk[g] <= f_sclk(g);
            end
        end
    end

    // Issues one read and reports the done cycle and first busy-low cycle.
    task automatic run_frame(input int g, input logic [1:0] a,
                             output int dcyc, output int bcyc);
        int n;
        if (g == 0) begin addr4 = a; start4 = 1'b1; end
        else        begin addr2 = a; start2 = 1'b1; end
        @(posedge clk); #1;
        start4 = 1'b0;
        start2 = 1'b0;
        dcyc = -1;
        bcyc = -1;
        n = 1;
        for (int k = 0; k < 400; k++) begin
            if (((g == 0) ? done4 : done2) === 1'b1) begin
                dcyc = n;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        for (int k = 0; k < 40; k++) begin
            if (((g == 0) ? busy4 : busy2) === 1'b0) begin
                bcyc = n;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({sclk4, csb4, mosi4, busy4, done4} !== 5'b11000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got sclk/csb/mosi/busy/done=%b expected 11000",
                     {sclk4, csb4, mosi4, busy4, done4});
        end
        tests_run++;
        if (data4 !== 16'h0000 || data2 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%h expected 0000/0000", data4, data2);
        end
        tests_run++;
        if ({sclk2, csb2, busy2} !== 3'b110) begin
            tests_failed++;
            $display("FAIL reset_div2: got sclk/csb/busy=%b expected 110", {sclk2, csb2, busy2});
        end
        start4 = 1'b0;
        reset  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int f0, p0, dcyc, bcyc;
        sregs[0][0] = 16'hA5C3;
        f0 = fall_cnt[0];
        p0 = phase_err[0];
        run_frame(0, 2'd0, dcyc, bcyc);
        tests_run++;
        if (dcyc !== 153) begin
            tests_failed++;
            $display("FAIL basic_done_cycle: got %0d expected 153", dcyc);
        end
        tests_run++;
        if (data4 !== 16'hA5C3) begin
            tests_failed++;
            $display("FAIL basic_data: got %h expected a5c3", data4);
        end
        tests_run++;
        if (fall_cnt[0] - f0 !== 18) begin
            tests_failed++;
            $display("FAIL basic_falls: got %0d expected 18", fall_cnt[0] - f0);
        end
        tests_run++;
        if (bcyc !== 157) begin
            tests_failed++;
            $display("FAIL basic_busy_fall: got %0d expected 157", bcyc);
        end
        tests_run++;
        if (phase_err[0] - p0 !== 0) begin
            tests_failed++;
            $display("FAIL basic_phase: got %0d bad phases expected 0", phase_err[0] - p0);
        end
    endtask

    task automatic test_addr();
        int dcyc, bcyc, bad;
        sregs[0][2] = 16'h1234;
        run_frame(0, 2'd2, dcyc, bcyc);
        tests_run++;
        if ({mosi_log[0][1], mosi_log[0][2]} !== 2'b10) begin
            tests_failed++;
            $display("FAIL addr_mosi: got p1/p2=%b expected 10", {mosi_log[0][1], mosi_log[0][2]});
        end
        bad = 0;
        for (int p = 3; p <= 18; p++) if (mosi_log[0][p] !== 1'b0) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL addr_mosi_tail: got %0d nonzero periods expected 0", bad);
        end
        tests_run++;
        if (data4 !== 16'h1234) begin
            tests_failed++;
            $display("FAIL addr_pc: got %h expected 1234", data4);
        end
        sregs[0][3] = 16'h0002;
        run_frame(0, 2'd3, dcyc, bcyc);
        tests_run++;
        if (data4 !== 16'h0002) begin
            tests_failed++;
            $display("FAIL addr_state: got %h expected 0002", data4);
        end
    endtask

    task automatic test_back_to_back();
        int dn, csb_hi, busy_lo;
        int dcy [3];
        logic [15:0] dat [3];
        sregs[0][0] = 16'h0001;
        sregs[0][1] = 16'h8000;
        sregs[0][2] = 16'hFFFF;
        dn = 0; csb_hi = 0; busy_lo = 0;
        for (int i = 0; i < 3; i++) begin dcy[i] = -1; dat[i] = 16'hxxxx; end
        addr4 = 2'd0;
        start4 = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 600; n++) begin
            if (n == 313) start4 = 1'b0;
            if (n <= 464) begin
                if (csb4 === 1'b1) csb_hi++;
                if (busy4 === 1'b0) busy_lo++;
            end
            if (done4 === 1'b1 && dn < 3) begin
                dcy[dn] = n;
                dat[dn] = data4;
                dn++;
                addr4 = 2'(dn);
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (dcy[0] !== 153 || dcy[1] !== 309 || dcy[2] !== 465) begin
            tests_failed++;
            $display("FAIL b2b_done_cycles: got %0d/%0d/%0d expected 153/309/465",
                     dcy[0], dcy[1], dcy[2]);
        end
        tests_run++;
        if (dat[0] !== 16'h0001 || dat[1] !== 16'h8000 || dat[2] !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL b2b_data: got %h/%h/%h expected 0001/8000/ffff",
                     dat[0], dat[1], dat[2]);
        end
        tests_run++;
        if (csb_hi !== 8) begin
            tests_failed++;
            $display("FAIL b2b_csb_gap: got %0d high cycles expected 8", csb_hi);
        end
        tests_run++;
        if (busy_lo !== 0) begin
            tests_failed++;
            $display("FAIL b2b_busy: got %0d idle cycles expected 0", busy_lo);
        end
        addr4 = 2'd0;
    endtask

    task automatic test_ignore_busy();
        int f0, dcyc, dones, late_low;
        sregs[0][0] = 16'h1357;
        sregs[0][1] = 16'h2468;
        f0 = fall_cnt[0];
        dcyc = -1; dones = 0; late_low = 0;
        addr4 = 2'd0;
        start4 = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 360; n++) begin
            if (n == 50) begin start4 = 1'b1; addr4 = 2'd1; end
            else start4 = 1'b0;
            if (done4 === 1'b1) begin
                dones++;
                if (dcyc < 0) dcyc = n;
            end
            if (n > 157 && csb4 !== 1'b1) late_low++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (dcyc !== 153 || dones !== 1) begin
            tests_failed++;
            $display("FAIL ignore_done: got cycle %0d count %0d expected 153 and 1", dcyc, dones);
        end
        tests_run++;
        if (data4 !== 16'h1357) begin
            tests_failed++;
            $display("FAIL ignore_data: got %h expected 1357", data4);
        end
        tests_run++;
        if (fall_cnt[0] - f0 !== 18 || late_low !== 0) begin
            tests_failed++;
            $display("FAIL ignore_extra_frame: got falls %0d late csb-low %0d expected 18 and 0",
                     fall_cnt[0] - f0, late_low);
        end
        addr4 = 2'd0;
    endtask

    task automatic test_reset_mid();
        int dcyc, bcyc;
        sregs[0][1] = 16'h5A5A;
        addr4 = 2'd0;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        tests_run++;
        if (csb4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_in_frame: got csb %b at cycle 80 expected 0", csb4);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++;
        if ({csb4, sclk4, busy4, mosi4, done4} !== 5'b11000 || data4 !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got csb/sclk/busy/mosi/done=%b data=%h expected 11000 0000",
                     {csb4, sclk4, busy4, mosi4, done4}, data4);
        end
        run_frame(0, 2'd1, dcyc, bcyc);
        tests_run++;
        if (dcyc !== 153 || data4 !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL rstmid_reread: got cycle %0d data %h expected 153 5a5a", dcyc, data4);
        end
    endtask

    task automatic test_min_div();
        int f0, p0, dcyc, bcyc;
        sregs[1][0] = 16'hC001;
        f0 = fall_cnt[1];
        p0 = phase_err[1];
        run_frame(1, 2'd0, dcyc, bcyc);
        tests_run++;
        if (dcyc !== 77) begin
            tests_failed++;
            $display("FAIL div2_done_cycle: got %0d expected 77", dcyc);
        end
        tests_run++;
        if (data2 !== 16'hC001) begin
            tests_failed++;
            $display("FAIL div2_data: got %h expected c001", data2);
        end
        tests_run++;
        if (phase_err[1] - p0 !== 0 || fall_cnt[1] - f0 !== 18) begin
            tests_failed++;
            $display("FAIL div2_phases: got %0d bad phases %0d falls expected 0 and 18",
                     phase_err[1] - p0, fall_cnt[1] - f0);
        end
        tests_run++;
        if (bcyc !== 79) begin
            tests_failed++;
            $display("FAIL div2_busy_fall: got %0d expected 79", bcyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        start4 = 1'b0;
        start2 = 1'b0;
        addr4  = 2'd0;
        addr2  = 2'd0;
        for (int g = 0; g < 2; g++)
            for (int a = 0; a < 4; a++) sregs[g][a] = 16'h0000;
        test_reset();
        test_basic();
        test_addr();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_min_div();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
